// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: IF/ID, writeback and ID/EX signal bundle around the decode stage.
interface id_ex_stage_if #(
   parameter int DATA_WIDTH       = 32,
   parameter int BUBBLE_CNT_WIDTH = 16
);
   logic [31:0]                 instruction;
   logic [DATA_WIDTH-1:0]       programCounterIn;
   logic                        validIn;
   logic [8:0]                  controlIn;
   logic                        immZeroExtend;
   logic [4:0]                  writeRegister;
   logic [DATA_WIDTH-1:0]       writeData;
   logic                        regWrite;
   logic                        flush;
   logic                        holdEx;
   logic [1:0]                  writeBackControl;
   logic [2:0]                  memAccessControl;
   logic [3:0]                  calculationControl;
   logic [DATA_WIDTH-1:0]       programCounterOut;
   logic [DATA_WIDTH-1:0]       readData1;
   logic [DATA_WIDTH-1:0]       readData2;
   logic [DATA_WIDTH-1:0]       immediateOperand;
   logic [4:0]                  rs;
   logic [4:0]                  rt;
   logic [4:0]                  rd;
   logic                        validOut;
   logic                        pcWrite;
   logic                        ifIdWrite;
   logic [BUBBLE_CNT_WIDTH-1:0] bubbleCount;

   modport master (
      output instruction, programCounterIn, validIn, controlIn, immZeroExtend,
             writeRegister, writeData, regWrite, flush, holdEx,
      input  writeBackControl, memAccessControl, calculationControl, programCounterOut,
             readData1, readData2, immediateOperand, rs, rt, rd, validOut,
             pcWrite, ifIdWrite, bubbleCount
   );

   modport slave (
      input  instruction, programCounterIn, validIn, controlIn, immZeroExtend,
             writeRegister, writeData, regWrite, flush, holdEx,
      output writeBackControl, memAccessControl, calculationControl, programCounterOut,
             readData1, readData2, immediateOperand, rs, rt, rd, validOut,
             pcWrite, ifIdWrite, bubbleCount
   );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode stage with bypassed register file, load-use stall, hold/flush and bubble counter.
module id_ex_stage #(
   parameter int DATA_WIDTH       = 32,
   parameter int REG_COUNT        = 32,
   parameter int IMM_WIDTH        = 16,
   parameter int BUBBLE_CNT_WIDTH = 16
) (
   input logic           clk,
   input logic           resetN,
   id_ex_stage_if.slave  bus
);
   localparam int IW = $clog2(REG_COUNT);

   logic [DATA_WIDTH-1:0]       regs_q [REG_COUNT];
   logic [DATA_WIDTH-1:0]       regs_d [REG_COUNT];
   logic [8:0]                  ctrl_q, ctrl_d;
   logic [DATA_WIDTH-1:0]       pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
   logic [4:0]                  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic                        valid_q, valid_d;
   logic [BUBBLE_CNT_WIDTH-1:0] bub_q, bub_d;
   logic [IW-1:0]               rs_idx, rt_idx, wr_idx, rt_out_idx;
   logic [DATA_WIDTH-1:0]       rd1, rd2, imm;
   logic                        hazard, load, sx;

   assign rs_idx     = bus.instruction[21 +: IW];
   assign rt_idx     = bus.instruction[16 +: IW];
   assign wr_idx     = bus.writeRegister[IW-1:0];
   assign rt_out_idx = rt_q[IW-1:0];
   assign rd1 = rs_idx == '0 ? '0 : (bus.regWrite && wr_idx == rs_idx) ? bus.writeData : regs_q[rs_idx];
   assign rd2 = rt_idx == '0 ? '0 : (bus.regWrite && wr_idx == rt_idx) ? bus.writeData : regs_q[rt_idx];
   assign sx  = ~bus.immZeroExtend & bus.instruction[IMM_WIDTH-1];
   // Shifting the fill pattern by IMM_WIDTH also covers IMM_WIDTH == DATA_WIDTH
   assign imm = ({DATA_WIDTH{sx}} << IMM_WIDTH) | DATA_WIDTH'(bus.instruction[IMM_WIDTH-1:0]);
   assign hazard = ctrl_q[5] & valid_q & bus.validIn & (rt_out_idx != '0) &
                   (rt_out_idx == rs_idx || rt_out_idx == rt_idx);
   assign load = bus.flush | ~bus.holdEx;

   always_comb begin
      regs_d = regs_q;
      if (bus.regWrite && wr_idx != '0) regs_d[wr_idx] = bus.writeData;
      ctrl_d  = load ? ((bus.flush | hazard | ~bus.validIn) ? '0 : bus.controlIn) : ctrl_q;
      valid_d = load ? (bus.validIn & ~bus.flush & ~hazard) : valid_q;
      pc_d    = load ? bus.programCounterIn : pc_q;
      rd1_d   = load ? rd1 : rd1_q;
      rd2_d   = load ? rd2 : rd2_q;
      imm_d   = load ? imm : imm_q;
      rs_d    = load ? bus.instruction[25:21] : rs_q;
      rt_d    = load ? bus.instruction[20:16] : rt_q;
      rd_d    = load ? bus.instruction[15:11] : rd_q;
      bub_d   = (~bus.flush & ~bus.holdEx & hazard & ~&bub_q) ? bub_q + 1'b1 : bub_q;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         regs_q  <= '{default: '0};
         ctrl_q  <= '0;
         pc_q    <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         valid_q <= 1'b0;
         bub_q   <= '0;
      end else begin
         regs_q  <= regs_d;
         ctrl_q  <= ctrl_d;
         pc_q    <= pc_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         imm_q   <= imm_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         valid_q <= valid_d;
         bub_q   <= bub_d;
      end
   end

   // Fetch enables must read 1 throughout reset, even if holdEx is high
   assign bus.pcWrite            = ~resetN | bus.flush | (~bus.holdEx & ~hazard);
   assign bus.ifIdWrite          = bus.pcWrite;
   assign bus.writeBackControl   = ctrl_q[8:7];
   assign bus.memAccessControl   = ctrl_q[6:4];
   assign bus.calculationControl = ctrl_q[3:0];
   assign bus.programCounterOut  = pc_q;
   assign bus.readData1          = rd1_q;
   assign bus.readData2          = rd2_q;
   assign bus.immediateOperand   = imm_q;
   assign bus.rs                 = rs_q;
   assign bus.rt                 = rt_q;
   assign bus.rd                 = rd_q;
   assign bus.validOut           = valid_q;
   assign bus.bubbleCount        = bub_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench driving a default instance and a REG_COUNT=8 / 2-bit-counter instance in lockstep.
module tb_id_ex_stage;
   typedef struct packed {
      logic [31:0] instr, pc;
      logic        valid;
      logic [8:0]  ctrl;
      logic        zext;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic        rw, flush, hold;
   } in_t;

   typedef struct packed {
      logic [8:0]  ctrl;
      logic [31:0] pc, rd1, rd2, imm;
      logic [4:0]  rs, rt, rd;
      logic        valid;
      logic [15:0] bub;
      logic        pcw;
   } exp_t;

   logic clk = 1'b0;
   logic resetN = 1'b0;
   int checks = 0, passed = 0;
   exp_t q0[$], q1[$];
   exp_t m[2];
   logic [31:0] mregs[2][32];

   id_ex_stage_if #(.DATA_WIDTH(32), .BUBBLE_CNT_WIDTH(16)) b0();
   id_ex_stage_if #(.DATA_WIDTH(32), .BUBBLE_CNT_WIDTH(2))  b1();

   id_ex_stage #(.DATA_WIDTH(32), .REG_COUNT(32), .IMM_WIDTH(16), .BUBBLE_CNT_WIDTH(16))
      dut0 (.clk(clk), .resetN(resetN), .bus(b0));
   id_ex_stage #(.DATA_WIDTH(32), .REG_COUNT(8), .IMM_WIDTH(16), .BUBBLE_CNT_WIDTH(2))
      dut1 (.clk(clk), .resetN(resetN), .bus(b1));

   always #5 clk = ~clk;

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) $display("FAIL %s actual=%h required=%h", n, a, e);
      else passed++;
   endtask

   task automatic cmp(string p, exp_t a, logic ifid, exp_t e);
      chk({p, "ctrl"}, 32'(a.ctrl), 32'(e.ctrl));
      chk({p, "pc"}, a.pc, e.pc);
      chk({p, "rd1"}, a.rd1, e.rd1);
      chk({p, "rd2"}, a.rd2, e.rd2);
      chk({p, "imm"}, a.imm, e.imm);
      chk({p, "rs_rt_rd"}, 32'({a.rs, a.rt, a.rd}), 32'({e.rs, e.rt, e.rd}));
      chk({p, "valid"}, 32'(a.valid), 32'(e.valid));
      chk({p, "bubbles"}, 32'(a.bub), 32'(e.bub));
      chk({p, "pcWrite"}, 32'(a.pcw), 32'(e.pcw));
      chk({p, "ifIdWrite"}, 32'(ifid), 32'(e.pcw));
   endtask

   // Monitor: whenever an expectation is queued, compare the visible outputs against it
   initial forever begin
      exp_t a, e;
      @(negedge clk);
      if (q0.size() != 0) begin
         e = q0.pop_front();
         a = {b0.writeBackControl, b0.memAccessControl, b0.calculationControl, b0.programCounterOut,
              b0.readData1, b0.readData2, b0.immediateOperand, b0.rs, b0.rt, b0.rd, b0.validOut,
              b0.bubbleCount, b0.pcWrite};
         cmp("i0.", a, b0.ifIdWrite, e);
      end
      if (q1.size() != 0) begin
         e = q1.pop_front();
         a = {b1.writeBackControl, b1.memAccessControl, b1.calculationControl, b1.programCounterOut,
              b1.readData1, b1.readData2, b1.immediateOperand, b1.rs, b1.rt, b1.rd, b1.validOut,
              16'(b1.bubbleCount), b1.pcWrite};
         cmp("i1.", a, b1.ifIdWrite, e);
      end
   end

   task automatic drive(in_t t);
      {b0.instruction, b0.programCounterIn, b0.validIn, b0.controlIn, b0.immZeroExtend,
       b0.writeRegister, b0.writeData, b0.regWrite, b0.flush, b0.holdEx} = t;
      {b1.instruction, b1.programCounterIn, b1.validIn, b1.controlIn, b1.immZeroExtend,
       b1.writeRegister, b1.writeData, b1.regWrite, b1.flush, b1.holdEx} = t;
   endtask

   // Called 1 time unit after a rising edge: queue what this cycle should show, then advance the model
   task automatic step(in_t t);
      logic [31:0] r1[2], r2[2], imm;
      logic        haz[2];
      int          rsi, rti, wi, lrt, mask, sat;
      exp_t        e;
      drive(t);
      imm = (t.instr[15] && !t.zext) ? {16'hFFFF, t.instr[15:0]} : {16'h0, t.instr[15:0]};
      for (int k = 0; k < 2; k++) begin
         mask = (k == 0) ? 31 : 7;
         rsi = int'(t.instr[25:21]) & mask;
         rti = int'(t.instr[20:16]) & mask;
         wi  = int'(t.wreg) & mask;
         lrt = int'(m[k].rt) & mask;
         r1[k] = rsi == 0 ? 0 : (t.rw && wi == rsi) ? t.wdata : mregs[k][rsi];
         r2[k] = rti == 0 ? 0 : (t.rw && wi == rti) ? t.wdata : mregs[k][rti];
         haz[k] = m[k].ctrl[5] && m[k].valid && t.valid && lrt != 0 && (lrt == rsi || lrt == rti);
         e = m[k];
         e.pcw = t.flush || (!t.hold && !haz[k]);
         if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         mask = (k == 0) ? 31 : 7;
         sat  = (k == 0) ? 65535 : 3;
         wi   = int'(t.wreg) & mask;
         if (t.rw && wi != 0) mregs[k][wi] = t.wdata;
         if (t.flush || !t.hold) begin
            m[k].pc = t.pc; m[k].rd1 = r1[k]; m[k].rd2 = r2[k]; m[k].imm = imm;
            m[k].rs = t.instr[25:21]; m[k].rt = t.instr[20:16]; m[k].rd = t.instr[15:11];
            if (t.flush || haz[k]) begin
               m[k].ctrl = 0;
               m[k].valid = 0;
               if (!t.flush && int'(m[k].bub) < sat) m[k].bub = m[k].bub + 1;
            end else begin
               m[k].ctrl = t.valid ? t.ctrl : 9'h0;
               m[k].valid = t.valid;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      exp_t e;
      resetN = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         m[k] = '0;
         for (int r = 0; r < 32; r++) mregs[k][r] = 0;
      end
      e = '0;
      e.pcw = 1'b1;
      q0.push_back(e);
      q1.push_back(e);
      @(posedge clk);
      #1;
      resetN = 1'b1;
   endtask

   function automatic in_t ins(int rs, int rt, logic [15:0] imm, logic [8:0] ctrl);
      in_t t;
      t = '0;
      t.instr = {6'h0, 5'(rs), 5'(rt), imm};
      t.pc = $urandom;
      t.valid = 1'b1;
      t.ctrl = ctrl;
      return t;
   endfunction

   function automatic in_t rnd();
      in_t t;
      t.instr = $urandom;
      if ($urandom_range(0, 1) == 1) t.instr[25:21] = 5'($urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) t.instr[20:16] = 5'($urandom_range(0, 4) + 8 * $urandom_range(0, 1));
      t.pc    = $urandom;
      t.valid = $urandom_range(0, 7) != 0;
      t.ctrl  = 9'($urandom);
      t.ctrl[5] = $urandom_range(0, 2) == 0;
      t.zext  = 1'($urandom_range(0, 1));
      t.wreg  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 4)) : 5'($urandom);
      t.wdata = $urandom;
      t.rw    = 1'($urandom_range(0, 1));
      t.flush = $urandom_range(0, 9) == 0;
      t.hold  = $urandom_range(0, 6) == 0;
      return t;
   endfunction

   localparam logic [8:0] LW = 9'b10_010_0001;
   localparam logic [8:0] ALU = 9'b01_000_0101;

   initial begin
      in_t t;
      drive('0);
      @(posedge clk);
      #1;
      do_reset();
      // Bypass, r0 write ignored, then array read
      t = ins(5, 0, 16'h0, ALU); t.rw = 1; t.wreg = 5; t.wdata = 32'hDEADBEEF; step(t);
      t = ins(0, 0, 16'h0, ALU); t.rw = 1; t.wreg = 0; t.wdata = 32'h1234; step(t);
      step(ins(5, 0, 16'h0, ALU));
      // Immediate extension
      step(ins(1, 2, 16'h8001, ALU));
      t = ins(1, 2, 16'h8001, ALU); t.zext = 1; step(t);
      // Five load-use stalls: saturates the 2-bit counter
      for (int n = 0; n < 5; n++) begin
         step(ins(0, 3, 16'h0, LW));
         step(ins(3, 0, 16'h0, ALU));
         step(ins(3, 0, 16'h0, ALU));
      end
      // Hold for three cycles over a pending hazard, then release
      step(ins(0, 3, 16'h0, LW));
      for (int n = 0; n < 3; n++) begin t = ins(3, 4, 16'h0, ALU); t.hold = 1; step(t); end
      step(ins(3, 4, 16'h0, ALU));
      step(ins(3, 4, 16'h0, ALU));
      // Flush together with a hazard
      step(ins(0, 3, 16'h0, LW));
      t = ins(3, 0, 16'h0, ALU); t.flush = 1; t.hold = 1; step(t);
      // REG_COUNT=8 index wrap: rt field 11 uses register 3 there
      t = ins(0, 0, 16'h0, ALU); t.rw = 1; t.wreg = 3; t.wdata = 32'hA5A5_0003; step(t);
      t = ins(0, 0, 16'h0, ALU); t.rw = 1; t.wreg = 11; t.wdata = 32'h0000_0B0B; step(t);
      step(ins(0, 11, 16'h0, ALU));
      for (int n = 0; n < 400; n++) step(rnd());
      // Reset while a load-use stall is pending and holdEx is high
      step(ins(0, 3, 16'h0, LW));
      t = ins(3, 0, 16'h0, ALU); t.hold = 1; drive(t);
      do_reset();
      for (int r = 0; r < 32; r++) step(ins(r, r, 16'h0, ALU));
      for (int n = 0; n < 300; n++) step(rnd());
      drive('0);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Parametrised instruction-decode stage with an integrated register file, load-use hazard detection, downstream hold, branch flush and a bubble statistics counter. It sits between the IF/ID register and the execute stage. It decodes the register fields of the current instruction, reads operands with write-through bypass and extends the immediate. It then registers everything, with the externally decoded control bundle, into the ID/EX pipeline register on the rising clock edge.

## Interface
- DATA_WIDTH, 32, register, operand and PC width
- REG_COUNT, 32, architectural registers; one of 8, 16, 32; index = low log2(REG_COUNT) bits of each 5-bit field
- IMM_WIDTH, 16, immediate field width taken from instruction[IMM_WIDTH-1:0]; ≤ DATA_WIDTH
- BUBBLE_CNT_WIDTH, 16, bubble counter width
- clk  in  1  clock; all state updates on rising edge
- resetN  in  1  asynchronous, active-low reset
- instruction  in  32  IF/ID instruction; rs=[25:21], rt=[20:16], rd=[15:11]
- programCounterIn  in  DATA_WIDTH  IF/ID PC
- validIn  in  1  IF/ID slot holds a real instruction
- controlIn  in  9  decoded control {writeBack[8:7], memAccess[6:4], calculation[3:0]}
- immZeroExtend  in  1  1 = zero-extend immediate, 0 = sign-extend
- writeRegister  in  5  writeback destination
- writeData  in  DATA_WIDTH  writeback data
- regWrite  in  1  writeback enable
- flush  in  1  squash the instruction in decode (branch taken)
- holdEx  in  1  execute cannot accept; freeze ID/EX
- writeBackControl  out  2  registered
- memAccessControl  out  3  registered; bit 1 = memRead
- calculationControl  out  4  registered
- programCounterOut, readData1, readData2, immediateOperand  out  DATA_WIDTH  registered
- rs, rt, rd  out  5  registered full fields
- validOut  out  1  registered
- pcWrite, ifIdWrite  out  1  combinational fetch enables
- bubbleCount  out  BUBBLE_CNT_WIDTH  saturating count of inserted bubbles

## Operation
- Register file: REG_COUNT × DATA_WIDTH. Register 0 reads as zero and ignores writes. Write on rising edge when regWrite=1 and the index ≠ 0.
- Read bypass: if regWrite=1 and the write index equals a nonzero read index, that read returns writeData in the same cycle.
- Immediate: instruction[IMM_WIDTH-1:0] is zero- or sign-extended to DATA_WIDTH according to immZeroExtend.
- Load-use hazard (hazard = 1) when all of the following hold:
  - memAccessControl[1]=1 and validOut=1;
  - rt output index ≠ 0;
  - rt output index equals the rs index or the rt index of the current instruction;
  - validIn=1.
- Per-edge priority, evaluated from current inputs:
  1. flush: ID/EX control and validOut load 0; data fields load normally; pcWrite=1, ifIdWrite=1.
  2. holdEx: every ID/EX output holds; pcWrite=0, ifIdWrite=0.
  3. hazard: control and validOut load 0 (bubble); pcWrite=0, ifIdWrite=0; bubbleCount increments.
  4. normal: all fields load; control loads controlIn if validIn=1, else 0; validOut=validIn; pcWrite=1, ifIdWrite=1.
- bubbleCount increments only in case 3 and saturates at 2^BUBBLE_CNT_WIDTH−1.
- Reset (resetN=0, asynchronous, at any time including mid-stall):
  - all registered outputs, the register file and bubbleCount go to 0 immediately;
  - pcWrite=1, ifIdWrite=1 (hazard cannot assert with validOut=0).

## Timing
- Latency: the decode of instruction at edge N appears on the outputs after edge N.
- Writeback at edge N into register r: a decode of r in the same cycle sees writeData through the bypass; later cycles read it from the array.
- A hazard stalls exactly one cycle. At the next edge the bubble (validOut=0) clears memRead, the hazard drops, and the held instruction issues.
- hazard and holdEx together: hold wins, bubbleCount unchanged, the hazard is re-evaluated next cycle.
- flush together with holdEx or hazard: flush wins, no bubble counted.
- pcWrite and ifIdWrite are combinational from flush, holdEx and the registered ID/EX state; they settle before the edge.

## Test plan
- Reset: assert resetN=0 mid-run → all outputs, bubbleCount and r1..r31 read 0, pcWrite=ifIdWrite=1.
- Bypass: regWrite=1, writeRegister=5, writeData=0xDEADBEEF, decode rs=5 in the same cycle → readData1=0xDEADBEEF next edge. A write to r0 → reads of r0 stay 0.
- Load-use: lw r3 issued (memAccess=3'b010), next instruction rs=3 → one bubble: validOut=0, controls 0, pcWrite=ifIdWrite=0 for one cycle, bubbleCount 0→1, then the instruction issues with rs=3.
- Hold/flush: holdEx=1 for 3 cycles → outputs frozen, pcWrite=0. flush=1 together with a hazard → validOut=0, bubbleCount unchanged, pcWrite=1.
- Immediate: 0x8001 with immZeroExtend=0 → 0xFFFF8001; with immZeroExtend=1 → 0x00008001.
- Saturation/params: BUBBLE_CNT_WIDTH=2 with 5 hazards → bubbleCount=3. REG_COUNT=8 and rt field 11 → register index 3 is used, and the rt output is 11.
